// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle controller in front of the 4-bit shifter_rotator. Accepts an operand, operation
//   and step count over a valid/ready handshake. It then runs the 1-bit combinational shifter
//   once per clock, feeding each result back as the next operand. The final value is returned
//   over a valid/ready output handshake.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request present
//   in_ready   out  1      high in IDLE
//   in_data    in   4      operand
//   in_op      in   2      00 SLL, 01 SRL, 10 ROL, 11 ROR
//   in_amt     in   AMT_W  number of 1-bit steps
//   sh_x       out  4      operand driven to the shifter
//   sh_sel     out  2      operation driven to the shifter
//   sh_y       in   4      shifter result (combinational from sh_x/sh_sel)
//   out_valid  out  1      high in DONE
//   out_ready  in   1      consumer accepts result
//   out_data   out  4      result
module shift_sequencer #(
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic [3:0]       sh_x,
    output logic [1:0]       sh_sel,
    input  logic [3:0]       sh_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= 4'b0000;
            op_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    op_d    = in_op;
                    cnt_d   = in_amt;
                    state_d = (in_amt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                // One shifter pass per clock; the count reaching 1 means this is the last pass.
                acc_d = sh_y;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs come only from registers or state decodes, so there is no input-to-output path.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = acc_q;
    assign sh_x      = acc_q;
    assign sh_sel    = op_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int unsigned AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [1:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic [3:0]       sh_x;
    logic [1:0]       sh_sel;
    logic [3:0]       sh_y;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;

    int n_checks = 0;
    int n_errors = 0;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_op    (in_op),
        .in_amt   (in_amt),
        .sh_x     (sh_x),
        .sh_sel   (sh_sel),
        .sh_y     (sh_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    // Shifter model following the assumed 1-bit contract.
    always_comb begin
        sh_y = 4'b0000;
        case (sh_sel)
            2'b00: sh_y = {sh_x[2:0], 1'b0};
            2'b01: sh_y = {1'b0, sh_x[3:1]};
            2'b10: sh_y = {sh_x[2:0], sh_x[3]};
            2'b11: sh_y = {sh_x[0], sh_x[3:1]};
            default: sh_y = 4'b0000;
        endcase
    end

    // Reference: whole-amount shift/rotate computed directly with integer arithmetic.
    function automatic logic [3:0] ref_result(input logic [1:0] op, input logic [3:0] d,
                                              input int amt);
        int v;
        int r;
        v = int'(d);
        r = amt % 4;
        case (op)
            2'b00:   v = (v << amt) & 15;
            2'b01:   v = v >> amt;
            2'b10:   v = ((v << r) | (v >> (4 - r))) & 15;
            default: v = ((v >> r) | (v << (4 - r))) & 15;
        endcase
        return v[3:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency, hold off for 'stall' cycles in DONE, then drain.
    task automatic run_req(input logic [1:0] op, input logic [3:0] data,
                           input logic [AMT_W-1:0] amt, input int stall);
        int edges;
        logic [3:0] exp;
        exp = ref_result(op, data, int'(amt));
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = data;
        in_amt    = amt;
        out_ready = (stall == 0);
        step();
        in_valid = 1'b0;
        // Inputs are free to change once accepted.
        in_data  = 4'($urandom);
        in_op    = 2'($urandom);
        in_amt   = AMT_W'($urandom);
        edges    = 0;
        while (!out_valid && edges < 20) begin
            step();
            edges++;
        end
        check("done_valid", {31'd0, out_valid}, 32'd1);
        check("latency", edges, int'(amt));
        check("result", {28'd0, out_data}, {28'd0, exp});
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            in_amt   = AMT_W'($urandom);
            step();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {28'd0, out_data}, {28'd0, exp});
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain_ready", {31'd0, in_ready}, 32'd1);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_odata"}, {28'd0, out_data}, 32'd0);
        check({tag, "_shx"}, {28'd0, sh_x}, 32'd0);
        check({tag, "_shsel"}, {30'd0, sh_sel}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        in_op     = 2'b00;
        in_amt    = '0;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed cases.
        run_req(2'b00, 4'b1011, 3'd1, 0);  // SLL -> 0110
        run_req(2'b10, 4'b1011, 3'd5, 0);  // ROL -> 0111
        run_req(2'b11, 4'b1011, 3'd2, 0);  // ROR -> 1110
        run_req(2'b01, 4'b1011, 3'd7, 0);  // SRL -> 0000
        run_req(2'b10, 4'b1001, 3'd0, 0);  // amt 0 -> 1001
        run_req(2'b00, 4'b1111, 3'd4, 0);  // SLL amt 4 -> 0000
        run_req(2'b01, 4'b1100, 3'd3, 3);  // backpressure

        // Asynchronous reset mid-cycle while in DONE.
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_data  = 4'b1011;
        in_amt   = 3'd0;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("pre_rst_done", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_done");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // Asynchronous reset during SHIFT of ROL amt 6: result must be discarded.
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_data  = 4'b0110;
        in_amt   = 3'd6;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid_shift_busy", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_shift");
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (out_valid) seen++;
            end
            check("no_stale_valid", seen, 0);
        end
        run_req(2'b00, 4'b0001, 3'd2, 0);  // SLL -> 0100

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_req(2'($urandom), 4'($urandom), AMT_W'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
